// File: rtl/ysyx_22040895_mdu_seq.sv
// ysyx_22040895_mdu_seq: multi-cycle RV64M MUL/DIV/DIVU/REM/REMU sequencer that
// borrows the shared integer ALU (one add/sub per cycle) while busy.
// Latency from accept: 1 cycle for special cases, 65 for MUL, 68 for div/rem.
// Backpressure: ready_o only in IDLE; result held in DONE until out_ready_i.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_i/ready_o               request handshake (op_i = funct3, wordop_i)
//   src1_i, src2_i                dividend/multiplicand, divisor/multiplier
//   flush_i                       kill in-flight op (wins over everything)
//   out_valid_o/out_ready_i       result handshake, result_o
//   alu_*                         operand/opcode drive into the shared ALU and
//                                 its result/borrow fed back
//
// Optional feature: define YSYX_22040895_MDU_WORD_EN to build the W-variants
// (MULW/DIVW/DIVUW/REMW/REMUW, 32 iterations). Undefined: wordop_i is ignored.

module ysyx_22040895_mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic            wordop_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            alu_own_o,
    output logic [3:0]      alu_aluop_o,
    output logic [XLEN-1:0] alu_op1_o,
    output logic [XLEN-1:0] alu_op2_o,
    output logic            alu_wordop_o,
    output logic            alu_shift_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_ltu_i
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP_A,
        S_PREP_B,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;      // MUL accumulator / partial remainder
    logic [XLEN-1:0] quo_q, quo_d;      // MUL multiplicand / dividend -> quotient
    logic [XLEN-1:0] dvs_q, dvs_d;      // MUL multiplier / divisor
    logic [XLEN-1:0] result_q, result_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            is_mul_q, is_mul_d;
    logic            is_sgn_q, is_sgn_d;
    logic            is_rem_q, is_rem_d;
    logic            word_q, word_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            ready_q, out_valid_q, alu_own_q;

    // Word-mode request qualifier; constant 0 when the W-variants are not built.
    logic word_req;
`ifdef YSYX_22040895_MDU_WORD_EN
    assign word_req = wordop_i;
`else
    logic unused_wordop;
    assign unused_wordop = wordop_i;
    assign word_req      = 1'b0;
`endif

    // Accept-time operand extension: signed ops sign-extend, unsigned zero-extend.
    logic            op_sgn;
    logic [XLEN-1:0] src1_x, src2_x;
    assign op_sgn = ~op_i[0];
    assign src1_x = word_req ? {{(XLEN-32){src1_i[31] & op_sgn}}, src1_i[31:0]} : src1_i;
    assign src2_x = word_req ? {{(XLEN-32){src2_i[31] & op_sgn}}, src2_i[31:0]} : src2_i;

    logic supported, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    assign supported = (op_i == 3'b000) | op_i[2];
    assign div_zero  = (src2_x == '0);
    assign div_ovf   = op_sgn & (&src2_x) &
                       ((src1_x == INT_MIN) |
                        (word_req & (src1_x == {{(XLEN-31){1'b1}}, 31'b0})));
    assign special   = ~supported | (op_i[2] & (div_zero | div_ovf));
    always_comb begin
        special_res = '0;
        if (supported && op_i[2]) begin
            if (div_zero)     special_res = op_i[1] ? src1_x : '1;
            else if (div_ovf) special_res = op_i[1] ? '0 : src1_x;
        end
    end

    // Restoring step; rem_q[63] set means the true trial value exceeds 2^64,
    // so the subtraction succeeds regardless of the ALU borrow.
    logic [XLEN-1:0] trial;
    logic            div_take;
    assign trial    = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign div_take = rem_q[XLEN-1] | ~alu_ltu_i;

    logic            last_iter;
    assign last_iter = (cnt_q == (word_q ? 6'd31 : 6'd63));

    logic [XLEN-1:0] fix_val;
    logic            fix_neg;
    assign fix_val = is_rem_q ? rem_q : quo_q;
    assign fix_neg = is_rem_q ? neg_rem_q : neg_quo_q;

    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] x);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        is_mul_d    = is_mul_q;
        is_sgn_d    = is_sgn_q;
        is_rem_d    = is_rem_q;
        word_d      = word_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        alu_aluop_o = ALU_ADD;
        alu_op1_o   = '0;
        alu_op2_o   = '0;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    is_mul_d  = (op_i == 3'b000);
                    is_sgn_d  = op_sgn;
                    is_rem_d  = op_i[1];
                    word_d    = word_req;
                    quo_d     = src1_x;
                    dvs_d     = src2_x;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    if (special) begin
                        result_d = fit(word_req, special_res);
                        state_d  = S_DONE;
                    end else if (op_i == 3'b000) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PREP_A;
                    end
                end
            end
            S_PREP_A: begin
                alu_aluop_o = ALU_SUB;
                alu_op2_o   = quo_q;
                neg_quo_d   = is_sgn_q & (quo_q[XLEN-1] ^ dvs_q[XLEN-1]);
                neg_rem_d   = is_sgn_q & quo_q[XLEN-1];
                quo_d       = (is_sgn_q & quo_q[XLEN-1]) ? alu_result_i : quo_q;
                // Word mode: park the 32-bit dividend in the top half so that
                // 32 shift steps consume exactly its bits.
                if (word_q) quo_d = {quo_d[31:0], 32'b0};
                state_d     = S_PREP_B;
            end
            S_PREP_B: begin
                alu_aluop_o = ALU_SUB;
                alu_op2_o   = dvs_q;
                dvs_d       = (is_sgn_q & dvs_q[XLEN-1]) ? alu_result_i : dvs_q;
                state_d     = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (is_mul_q) begin
                    alu_aluop_o = ALU_ADD;
                    alu_op1_o   = rem_q;
                    alu_op2_o   = dvs_q[0] ? quo_q : '0;
                    rem_d       = alu_result_i;
                    quo_d       = {quo_q[XLEN-2:0], 1'b0};
                    dvs_d       = {1'b0, dvs_q[XLEN-1:1]};
                    if (last_iter) begin
                        result_d = fit(word_q, alu_result_i);
                        state_d  = S_DONE;
                    end
                end else begin
                    alu_aluop_o = ALU_SUB;
                    alu_op1_o   = trial;
                    alu_op2_o   = dvs_q;
                    rem_d       = div_take ? alu_result_i : trial;
                    quo_d       = {quo_q[XLEN-2:0], div_take};
                    if (last_iter) state_d = S_FIX;
                end
            end
            S_FIX: begin
                alu_aluop_o = ALU_SUB;
                alu_op2_o   = fix_val;
                result_d    = fit(word_q, fix_neg ? alu_result_i : fix_val);
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            is_mul_q    <= 1'b0;
            is_sgn_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            word_q      <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            alu_own_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            is_mul_q    <= is_mul_d;
            is_sgn_q    <= is_sgn_d;
            is_rem_q    <= is_rem_d;
            word_q      <= word_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ready_q     <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            alu_own_q   <= (state_d == S_PREP_A) || (state_d == S_PREP_B) ||
                           (state_d == S_RUN)    || (state_d == S_FIX);
        end
    end

    assign ready_o      = ready_q;
    assign out_valid_o  = out_valid_q;
    assign alu_own_o    = alu_own_q;
    assign result_o     = result_q;
    assign alu_wordop_o = 1'b0;
    assign alu_shift_o  = 1'b0;

endmodule

// File: tb/tb_ysyx_22040895_mdu_seq.sv
module tb_ysyx_22040895_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic        wordop_i;
    logic [63:0] src1_i, src2_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] result_o;
    logic        alu_own_o;
    logic [3:0]  alu_aluop_o;
    logic [63:0] alu_op1_o, alu_op2_o;
    logic        alu_wordop_o, alu_shift_o;
    logic [63:0] alu_result_i;
    logic        alu_ltu_i;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    // Shared integer ALU stand-in: add/sub plus unsigned borrow.
    assign alu_result_i = (alu_aluop_o == 4'b0001) ? alu_op1_o - alu_op2_o : alu_op1_o + alu_op2_o;
    assign alu_ltu_i    = alu_op1_o < alu_op2_o;

    ysyx_22040895_mdu_seq #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .wordop_i(wordop_i), .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .alu_own_o(alu_own_o), .alu_aluop_o(alu_aluop_o), .alu_op1_o(alu_op1_o),
        .alu_op2_o(alu_op2_o), .alu_wordop_o(alu_wordop_o), .alu_shift_o(alu_shift_o),
        .alu_result_i(alu_result_i), .alu_ltu_i(alu_ltu_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        case (op)
            3'b000: r = a * b;
            3'b100: if (b == 0) r = ONES; else if (a == MIN64 && b == ONES) r = a;
                    else r = $signed(a) / $signed(b);
            3'b101: r = (b == 0) ? ONES : a / b;
            3'b110: if (b == 0) r = a; else if (a == MIN64 && b == ONES) r = 0;
                    else r = $signed(a) % $signed(b);
            3'b111: r = (b == 0) ? a : a % b;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b000: r = a * b;
            3'b100: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a;
                    else r = $signed(a) / $signed(b);
            3'b101: r = (b == 0) ? '1 : a / b;
            3'b110: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = 0;
                    else r = $signed(a) % $signed(b);
            3'b111: r = (b == 0) ? a : a % b;
            default: r = 0;
        endcase
        return {{32{r[31]}}, r};
    endfunction

    function automatic bit word_on(input logic w);
`ifdef YSYX_22040895_MDU_WORD_EN
        return w;
`else
        return 1'b0 & w;
`endif
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        return word_on(w) ? ref32(op, a[31:0], b[31:0]) : ref64(op, a, b);
    endfunction

    // Cycles from the accepting edge to the first cycle with out_valid_o high.
    function automatic int exp_lat(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        bit wd, spec;
        wd = word_on(w);
        if (op != 3'b000 && !op[2]) return 1;
        if (op == 3'b000) return wd ? 33 : 65;
        if (wd) spec = (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else    spec = (b == 0) || (!op[0] && a == MIN64 && b == ONES);
        return spec ? 1 : (wd ? 36 : 68);
    endfunction

    // Issue one request, check latency, ALU ownership span and result, hold the
    // result for 'hold' cycles, then accept it and check the return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        int k, own;
        logic [63:0] exp;
        exp = ref_result(op, w, a, b);
        check({tag, "_ready"}, {63'b0, ready_o}, 64'd1);
        valid_i = 1'b1; op_i = op; wordop_i = w; src1_i = a; src2_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0; src1_i = $urandom; src2_i = $urandom;
        k = 1; own = 0;
        while (!out_valid_o && k < 200) begin
            own += int'(alu_own_o);
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(exp_lat(op, w, a, b)));
        check({tag, "_own"}, 64'(own), 64'(exp_lat(op, w, a, b) - 1));
        check({tag, "_res"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {result_o, ready_o, out_valid_o}, {exp, 1'b0, 1'b1});
        end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check({tag, "_idle"}, {62'b0, ready_o, out_valid_o}, 64'b10);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [63:0] ra, rb;
        rst = 1'b1; valid_i = 1'b0; op_i = 3'b0; wordop_i = 1'b0; src1_i = '0; src2_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {59'b0, ready_o, out_valid_o, alu_own_o, alu_wordop_o, alu_shift_o}, 64'b10000);
        check("reset_res", result_o, 64'd0);
        check("reset_alu", alu_op1_o | alu_op2_o | {60'b0, alu_aluop_o}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_neg", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("div_neg", 3'b100, 1'b0, -64'sd7, 64'd2, 0);
        run_op("rem_neg", 3'b110, 1'b0, -64'sd7, 64'd2, 0);
        run_op("divu", 3'b101, 1'b0, 64'd100, 64'd7, 10);
        run_op("divu_z", 3'b101, 1'b0, 64'd5, 64'd0, 0);
        run_op("remu_z", 3'b111, 1'b0, 64'd5, 64'd0, 0);
        run_op("div_ovf", 3'b100, 1'b0, MIN64, ONES, 0);
        run_op("rem_ovf", 3'b110, 1'b0, MIN64, ONES, 0);
        run_op("unsup", 3'b010, 1'b0, 64'd9, 64'd3, 0);
        run_op("divu_big", 3'b101, 1'b0, ONES, 64'h8000_0000_0000_0001, 0);
        run_op("remu_big", 3'b111, 1'b0, ONES, 64'h8000_0000_0000_0001, 0);

        // Flush in the middle of a multiply.
        valid_i = 1'b1; op_i = 3'b000; src1_i = 64'd5; src2_i = 64'd9;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_flush_own", {63'b0, alu_own_o}, 64'd1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_idle", {61'b0, ready_o, out_valid_o, alu_own_o}, 64'b100);
        repeat (3) @(posedge clk);
        #1;
        check("flush_quiet", {63'b0, out_valid_o}, 64'd0);
        run_op("mul_after_flush", 3'b000, 1'b0, 64'd3, 64'd4, 0);

        // Flush beats a new accept.
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; src1_i = 64'd1; src2_i = 64'd0;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_vs_accept", {62'b0, ready_o, out_valid_o}, 64'b10);

        // Flush beats the DONE handshake.
        valid_i = 1'b1; op_i = 3'b101; src1_i = 64'd1; src2_i = 64'd0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("spec_done", {63'b0, out_valid_o}, 64'd1);
        flush_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; out_ready_i = 1'b0;
        check("flush_in_done", {62'b0, ready_o, out_valid_o}, 64'b10);

        // Synchronous reset mid-divide discards everything.
        valid_i = 1'b1; op_i = 3'b100; src1_i = 64'd1000; src2_i = 64'd3;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ctl", {61'b0, ready_o, out_valid_o, alu_own_o}, 64'b100);
        check("rst_mid_res", result_o, 64'd0);

`ifdef YSYX_22040895_MDU_WORD_EN
        run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 0);
        run_op("divw_ovf", 3'b100, 1'b1, 64'h8000_0000, ONES, 0);
        run_op("divw", 3'b100, 1'b1, 64'hFFFF_FFF9, 64'd2, 0);
        run_op("remuw", 3'b111, 1'b1, 64'hFFFF_FFF9, 64'd10, 0);
`else
        run_op("w_ignored", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            rop = (sel == 0) ? 3'($urandom_range(1, 3)) : ((sel < 3) ? 3'b000 : {1'b1, 2'($urandom)});
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'd0;
                1: begin ra = MIN64; rb = ONES; end
                2: rb = 64'($urandom_range(1, 50));
                3: rb = {{32{rb[31]}}, rb[31:0]};
                4: ra = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op("rand", rop, 1'($urandom), ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_mdu_seq.md
# ysyx_22040895_mdu_seq

Multi-cycle multiply/divide sequencer for the EXU. It implements RV64M MUL/DIV/DIVU/REM/REMU by iterating over the shared integer ALU, one ALU operation per cycle, instead of instantiating its own wide adder. While busy it takes ownership of the ALU operand/opcode mux, and the EXU stalls on `ready_o`.

## Interface
Parameters:
- `XLEN`, 64: datapath width; only 64 is supported.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `valid_i`  in  1: request valid.
- `ready_o`  out  1: sequencer can accept; high only in IDLE.
- `op_i`  in  3: funct3 (000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 unsupported).
- `wordop_i`  in  1: W-variant request (see Configuration).
- `src1_i`, `src2_i`  in  64: dividend/multiplicand, divisor/multiplier.
- `flush_i`  in  1: kill the in-flight operation.
- `out_valid_o`  out  1: result valid; held until accepted.
- `out_ready_i`  in  1: consumer accepts the result.
- `result_o`  out  64: result.
- `alu_own_o`  out  1: ALU mux selects the sequencer operands.
- `alu_aluop_o`  out  4: ALU opcode (0000 add, 0001 sub).
- `alu_op1_o`, `alu_op2_o`  out  64: ALU operands.
- `alu_wordop_o`, `alu_shift_o`  out  1: tied 0.
- `alu_result_i`  in  64: ALU result.
- `alu_ltu_i`  in  1: unsigned less-than (borrow) from the ALU.

## Operation
- States: IDLE, PREP_A, PREP_B, RUN, FIX, DONE.
- IDLE: `ready_o`=1. On `valid_i`, latch the operands and the op and clear the iteration counter, then go to:
  - DONE: special case or unsupported op.
  - RUN: MUL.
  - PREP_A: div/rem.
- Special cases, resolved at accept (next state DONE):
  - Divisor 0: DIV/DIVU → 0xFFFF_FFFF_FFFF_FFFF; REM/REMU → dividend.
  - DIV with 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF: DIV → dividend; REM → 0.
  - Unsupported funct3: result 0.
- PREP_A / PREP_B (signed div/rem only negate; unsigned passes through; both states always take 1 cycle each):
  - PREP_A: ALU sub 0−src1 if src1[63]=1, giving |dividend|.
  - PREP_B: ALU sub 0−src2 if src2[63]=1, giving |divisor|.
  - Record the quotient sign (s1^s2) and the remainder sign (s1).
- RUN, MUL (64 iterations, one per cycle):
  - ALU add: acc + (mplier[0] ? mcand : 0).
  - Then acc ← result, mcand <<= 1, mplier >>= 1.
  - Low 64 bits only, so the result is sign-agnostic.
- RUN, DIV (restoring, 64 iterations):
  - trial = {rem[62:0], quo[63]}.
  - ALU sub trial − divisor.
  - If `alu_ltu_i`=0: rem ← `alu_result_i` and shift 1 into quo. Else: rem ← trial and shift 0 into quo.
- FIX (div/rem only, always 1 cycle): ALU sub 0−x when the relevant sign is set; otherwise pass through.
- DONE: `out_valid_o`=1 with a stable `result_o`. On `out_ready_i`, go to IDLE.
- `alu_own_o`=1 in PREP_A, PREP_B, RUN and FIX; otherwise 0, and the ALU outputs are driven to 0.
- `flush_i`: from any state, next state is IDLE with no `out_valid_o`. `flush_i` takes priority over the DONE handshake and over a new accept.

## Timing
- Reset values:
  - State: IDLE; `ready_o`=1.
  - `out_valid_o`, `alu_own_o` = 0.
  - `result_o`, `alu_op1_o`, `alu_op2_o`, `alu_aluop_o` = 0.
  - All internal registers 0.
- With the request accepted at edge T, `out_valid_o` first rises at T+1 for special cases, T+65 for MUL and T+68 for div/rem.
- A result accepted in cycle N allows a new accept no earlier than N+1, because `ready_o` rises only after DONE→IDLE. There is no back-to-back overlap.
- Reset mid-operation: the next cycle is IDLE; the partial result is discarded.
- `out_ready_i` is ignored outside DONE.

## Configuration
- `YSYX_22040895_MDU_WORD_EN` defined:
  - `wordop_i` selects MULW/DIVW/DIVUW/REMW/REMUW.
  - At accept, operands are sign-extended (signed ops) or zero-extended (unsigned ops) from bit 31.
  - RUN runs 32 iterations.
  - Results are sign-extended from bit 31.
  - Latency: T+33 (MULW), T+36 (div/rem W).
  - 32-bit overflow: DIVW 0x8000_0000/−1 → 0xFFFF_FFFF_8000_0000.
- Not defined: `wordop_i` is ignored and treated as 0; the 32-iteration path is not built.

## Test plan
- MUL 7 × 0xFFFF_FFFF_FFFF_FFFD → 0xFFFF_FFFF_FFFF_FFEB; `out_valid_o` at T+65; `alu_own_o` high for exactly 64 cycles.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 → 14 at T+68.
- Divide by 0: DIVU 5/0 → all-ones; REMU 5/0 → 5; DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000; all at T+1.
- Hold `out_ready_i`=0 for 10 cycles in DONE: `result_o` stable and `ready_o`=0 throughout; release → IDLE on the next edge.
- `flush_i` at RUN iteration 20 → IDLE next cycle, no `out_valid_o`; a new MUL 3×4 → 12 at T+65.
- With the macro: MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE at T+33; DIVW 0x8000_0000/−1 → 0xFFFF_FFFF_8000_0000.
